// File: rtl/sr_cmd_gen.sv
// SR flip-flop command stage: synchronises, debounces and edge-detects two raw request lines.
// Emits mutually exclusive S/R pulses. Define SR_CMD_STAT_EN to add saturating pulse counters.
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req_raw,
  input  logic       rst_req_raw,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       conflict
`ifdef SR_CMD_STAT_EN
  ,
  output logic [7:0] set_cnt,
  output logic [7:0] rst_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PCW   = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StPulseS, StPulseR} state_e;

  // Bit 0 is the set channel, bit 1 the reset channel.
  logic [1:0]       sync1_q, sync2_q, deb_q, deb_dly_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       req;

  state_e           state_q;
  logic [PCW-1:0]   pcnt_q;
  logic             pend_set_q, pend_rst_q;
  logic             eff_set, eff_rst;

  assign req     = deb_q & ~deb_dly_q;
  assign eff_set = req[0] | pend_set_q;
  assign eff_rst = req[1] | pend_rst_q;
  assign busy    = (state_q != StIdle) | pend_set_q | pend_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= {rst_req_raw, set_req_raw};
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEB_CYCLES)) begin
          deb_q[i] <= ~deb_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pcnt_q     <= '0;
      pend_set_q <= 1'b0;
      pend_rst_q <= 1'b0;
      S          <= 1'b0;
      R          <= 1'b0;
      conflict   <= 1'b0;
`ifdef SR_CMD_STAT_EN
      set_cnt    <= '0;
      rst_cnt    <= '0;
`endif
    end else begin
      conflict <= 1'b0;
      case (state_q)
        StIdle: begin
          // Reset wins a tie; the set request is dropped rather than queued.
          if (eff_rst) begin
            state_q    <= StPulseR;
            R          <= 1'b1;
            conflict   <= eff_set;
            pend_set_q <= 1'b0;
            pend_rst_q <= 1'b0;
            pcnt_q     <= PCW'(PULSE_CYCLES - 1);
`ifdef SR_CMD_STAT_EN
            if (rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 1'b1;
`endif
          end else if (eff_set) begin
            state_q    <= StPulseS;
            S          <= 1'b1;
            pend_set_q <= 1'b0;
            pcnt_q     <= PCW'(PULSE_CYCLES - 1);
`ifdef SR_CMD_STAT_EN
            if (set_cnt != 8'hFF) set_cnt <= set_cnt + 1'b1;
`endif
          end
        end
        default: begin
          if (req[0]) pend_set_q <= 1'b1;
          if (req[1]) pend_rst_q <= 1'b1;
          // Returning to idle forces a gap cycle before the next pulse.
          if (pcnt_q == '0) begin
            state_q <= StIdle;
            S       <= 1'b0;
            R       <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: a timeline model predicts each pulse (kind, start edge, conflict)
// and a negedge monitor pops and compares whenever S or R rises.
module tb_sr_cmd_gen;
  localparam int unsigned DEB = 4;
  localparam int unsigned P   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_raw = 1'b0;
  logic rst_raw = 1'b0;
  logic S, R, busy, conflict;
`ifdef SR_CMD_STAT_EN
  logic [7:0] set_cnt, rst_cnt;
`endif

  sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_CYCLES(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_req_raw(set_raw),
    .rst_req_raw(rst_raw),
    .S          (S),
    .R          (R),
    .busy       (busy),
    .conflict   (conflict)
`ifdef SR_CMD_STAT_EN
    ,
    .set_cnt    (set_cnt),
    .rst_cnt    (rst_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {bit is_r; int start; bit conf; int sc; int rc;} exp_t;
  exp_t exp_q[$];

  // Reference model state: timeline of requests and pulse occupancy.
  int edge_n = -1;
  bit hist0[$];
  bit hist1[$];
  bit lvl[2];
  int run[2];
  bit req_next[2];
  bit pend[2];
  int free_at, pulse_end, sc, rc;
  bit exp_busy;

  task automatic model_reset();
    hist0.delete(); hist0.push_back(1'b0); hist0.push_back(1'b0);
    hist1.delete(); hist1.push_back(1'b0); hist1.push_back(1'b0);
    lvl = '{0, 0}; run = '{0, 0}; req_next = '{0, 0}; pend = '{0, 0};
    free_at = 0; pulse_end = 0; sc = 0; rc = 0; exp_busy = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit ev[2];
    bit syn[2];
    bit eff_s, eff_r;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = req_next;
    req_next = '{0, 0};
    if (edge_n >= free_at) begin
      eff_s = ev[0] | pend[0];
      eff_r = ev[1] | pend[1];
      if (eff_r) begin
        if (rc < 255) rc++;
        exp_q.push_back('{1'b1, edge_n, eff_s, sc, rc});
        free_at = edge_n + P + 1; pulse_end = edge_n + P; pend = '{0, 0};
      end else if (eff_s) begin
        if (sc < 255) sc++;
        exp_q.push_back('{1'b0, edge_n, 1'b0, sc, rc});
        free_at = edge_n + P + 1; pulse_end = edge_n + P; pend[0] = 1'b0;
      end
    end else begin
      pend[0] |= ev[0];
      pend[1] |= ev[1];
    end
    exp_busy = (edge_n < pulse_end) || pend[0] || pend[1];
    // Two-sample synchroniser latency, then a level flips after DEB+1 disagreeing samples.
    hist0.push_back(set_raw); syn[0] = hist0.pop_front();
    hist1.push_back(rst_raw); syn[1] = hist1.pop_front();
    for (int ch = 0; ch < 2; ch++) begin
      if (syn[ch] != lvl[ch]) begin
        run[ch]++;
        if (run[ch] == DEB + 1) begin
          lvl[ch] = ~lvl[ch];
          run[ch] = 0;
          if (lvl[ch]) req_next[ch] = 1'b1;
        end
      end else begin
        run[ch] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor
  bit prev_s, prev_r;
  int s_pulses = 0, r_pulses = 0;
  int s_start = -1, r_start = -1;
  bit last_r_conf;

  task automatic monitor_step();
    bit s_rise, r_rise;
    exp_t e;
    if (!rst_n) begin
      prev_s = 1'b0; prev_r = 1'b0;
      return;
    end
    tests++;
    assert (!(S && R)) else begin
      fails++;
      $display("FAIL sr_exclusive edge=%0d S=%0b R=%0b required S&R=0", edge_n, S, R);
    end
    tests++;
    if (busy !== exp_busy) begin
      fails++;
      $display("FAIL busy edge=%0d got=%0b exp=%0b", edge_n, busy, exp_busy);
    end
    s_rise = S && !prev_s;
    r_rise = R && !prev_r;
    tests++;
    if (conflict && !r_rise) begin
      fails++;
      $display("FAIL conflict_alone edge=%0d got=1 exp=0", edge_n);
    end
    if (s_rise || r_rise) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse edge=%0d S=%0b R=%0b exp=none", edge_n, S, R);
      end else begin
        e = exp_q.pop_front();
        if (e.is_r != r_rise || e.start != edge_n || e.conf != conflict) begin
          fails++;
          $display("FAIL pulse edge=%0d got is_r=%0b conf=%0b exp is_r=%0b start=%0d conf=%0b",
                   edge_n, r_rise, conflict, e.is_r, e.start, e.conf);
        end
`ifdef SR_CMD_STAT_EN
        tests++;
        if (int'(set_cnt) != e.sc || int'(rst_cnt) != e.rc) begin
          fails++;
          $display("FAIL stat_cnt got set=%0d rst=%0d exp set=%0d rst=%0d",
                   set_cnt, rst_cnt, e.sc, e.rc);
        end
`endif
      end
      if (s_rise) begin s_pulses++; s_start = edge_n; end
      if (r_rise) begin r_pulses++; r_start = edge_n; last_r_conf = conflict; end
    end
    if (!S && prev_s) begin
      tests++;
      if (edge_n - s_start != P) begin
        fails++;
        $display("FAIL s_width got=%0d exp=%0d", edge_n - s_start, P);
      end
    end
    if (!R && prev_r) begin
      tests++;
      if (edge_n - r_start != P) begin
        fails++;
        $display("FAIL r_width got=%0d exp=%0d", edge_n - r_start, P);
      end
    end
    prev_s = S;
    prev_r = R;
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Waits (bounded) for the next S or R pulse start; returns its edge or -1.
  task automatic wait_pulse(input bit want_r, output int at);
    int c0;
    c0 = want_r ? r_pulses : s_pulses;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if ((want_r ? r_pulses : s_pulses) != c0) begin
        at = want_r ? r_start : s_start;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_pulse_timeout want_r=%0b got=none exp=pulse", want_r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, at, ts, s0, r0;
    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      set_raw = 1'($urandom); rst_raw = 1'($urandom);
      cyc(1);
      check("reset_outputs", {S, R, busy, conflict}, 0);
    end
    set_raw = 0; rst_raw = 0;
    rst_n = 1'b1;
    cyc(20);
    check("idle_after_reset", s_pulses + r_pulses, 0);

    // Clean set
    set_raw = 1; e0 = edge_n + 1; r0 = r_pulses;
    wait_pulse(1'b0, at);
    check("set_latency", at, e0 + DEB + 3);
    cyc(6);
    check("set_no_r", r_pulses, r0);
    set_raw = 0;
    cyc(20);

    // Bounce then stable rise
    s0 = s_pulses;
    for (int i = 0; i < 10; i++) begin
      set_raw = ~set_raw;
      cyc(2);
    end
    set_raw = 1; e0 = edge_n + 1;
    wait_pulse(1'b0, at);
    check("bounce_latency", at, e0 + DEB + 3);
    cyc(20);
    check("bounce_one_pulse", s_pulses - s0, 1);
    set_raw = 0;
    cyc(20);

    // Simultaneous requests
    s0 = s_pulses; r0 = r_pulses;
    set_raw = 1; rst_raw = 1;
    wait_pulse(1'b1, at);
    check("simul_conflict", last_r_conf, 1);
    cyc(20);
    check("simul_no_s", s_pulses - s0, 0);
    check("simul_one_r", r_pulses - r0, 1);
    set_raw = 0; rst_raw = 0;
    cyc(20);

    // Reset request queued behind an S pulse
    set_raw = 1;
    cyc(2);
    rst_raw = 1;
    wait_pulse(1'b0, ts);
    wait_pulse(1'b1, at);
    check("queued_gap", at - ts, P + 1);
    set_raw = 0; rst_raw = 0;
    cyc(20);

    // Reset mid R pulse with set pending
    s0 = s_pulses;
    rst_raw = 1;
    cyc(2);
    set_raw = 1;
    wait_pulse(1'b1, at);
    cyc(2);
    check("pend_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_drop", {S, R, busy}, 0);
    set_raw = 0;
    cyc(3);
    rst_n = 1'b1; e0 = edge_n + 1;
    wait_pulse(1'b1, at);
    check("fresh_after_reset", at, e0 + DEB + 3);
    cyc(20);
    check("pending_lost", s_pulses - s0, 0);
    rst_raw = 0;
    cyc(20);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      set_raw = 1'($urandom); rst_raw = 1'($urandom);
      cyc($urandom_range(1, 12));
    end
    set_raw = 0; rst_raw = 0;
    cyc(40);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
